// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing with Avalon stalls.
// Optional feature: define MIPS_DELAY_SLOT_EN to run one delay-slot instruction before a taken transfer redirects the PC.
module mips_multicycle_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           instr,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    input  logic                  waitrequest,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  ir_load,
    output logic                  alu_src,
    output logic [1:0]            reg_dst,
    output logic                  reg_write,
    output logic                  mem_to_reg,
    output logic                  link,
    output logic                  tgt_latch,
    output logic [1:0]            tgt_sel,
    output logic                  pc_write,
    output logic                  pc_sel,
    output logic                  active,
    output logic [2:0]            state
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t cur;
    logic   taken_q;
    logic   halt_q;
    logic   in_slot;
    logic   wb_pc_sel;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    logic       unused_bits;

    assign op          = instr[31:26];
    assign rt          = instr[20:16];
    assign funct       = instr[5:0];
    assign unused_bits = ^{instr[25:21], instr[15:6]};

    logic is_r, is_jr, is_jalr, is_j, is_jal, is_load, is_store, is_ialu;
    logic is_beq, is_bne, is_blez, is_bgtz, is_bltz, is_bgez, is_bltzal, is_bgezal;
    logic link31, writes, rs_zero, rs_neg, cond_taken, halt_cond;

    assign is_r      = (op == 6'd0);
    assign is_jr     = is_r && (funct == 6'd8);
    assign is_jalr   = is_r && (funct == 6'd9);
    assign is_j      = (op == 6'd2);
    assign is_jal    = (op == 6'd3);
    assign is_load   = (op[5:3] == 3'b100);
    assign is_store  = (op == 6'd43);
    assign is_ialu   = (op[5:3] == 3'b001);
    assign is_beq    = (op == 6'd4);
    assign is_bne    = (op == 6'd5);
    assign is_blez   = (op == 6'd6) && (rt == 5'd0);
    assign is_bgtz   = (op == 6'd7) && (rt == 5'd0);
    assign is_bltz   = (op == 6'd1) && (rt == 5'd0);
    assign is_bgez   = (op == 6'd1) && (rt == 5'd1);
    assign is_bltzal = (op == 6'd1) && (rt == 5'd16);
    assign is_bgezal = (op == 6'd1) && (rt == 5'd17);

    // Sign test on the MSB keeps the comparisons width-generic.
    assign rs_zero = (rs_data == '0);
    assign rs_neg  = rs_data[DATA_WIDTH-1];

    assign cond_taken = (is_beq && (rs_data == rt_data))
                      | (is_bne && (rs_data != rt_data))
                      | (is_blez && (rs_neg || rs_zero))
                      | (is_bgtz && !rs_neg && !rs_zero)
                      | ((is_bltz || is_bltzal) && rs_neg)
                      | ((is_bgez || is_bgezal) && !rs_neg)
                      | is_j | is_jal | is_jr | is_jalr;
    assign halt_cond  = (is_jr || is_jalr) && rs_zero;
    assign link31     = is_jal | is_bltzal | is_bgezal;
    assign writes     = (is_r && !is_jr) | is_ialu | is_load | link31;

`ifdef MIPS_DELAY_SLOT_EN
    logic pending_q;
    assign in_slot   = pending_q;
    assign wb_pc_sel = pending_q;
`else
    assign in_slot   = 1'b0;
    assign wb_pc_sel = taken_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            cur     <= S_FETCH;
            taken_q <= 1'b0;
            halt_q  <= 1'b0;
`ifdef MIPS_DELAY_SLOT_EN
            pending_q <= 1'b0;
`endif
        end else begin
            case (cur)
                S_FETCH:  if (!waitrequest) cur <= S_DECODE;
                S_DECODE: begin
                    cur <= S_EXEC;
                    // A transfer sitting in a delay slot must not disturb the outstanding one.
                    if (!in_slot) begin
                        taken_q <= cond_taken;
                        halt_q  <= cond_taken && halt_cond;
                    end
                end
                S_EXEC:   cur <= (is_load || is_store) ? S_MEM : S_WB;
                S_MEM:    if (!waitrequest) cur <= S_WB;
                S_WB: begin
`ifdef MIPS_DELAY_SLOT_EN
                    if (pending_q) begin
                        pending_q <= 1'b0;
                        cur       <= halt_q ? S_HALT : S_FETCH;
                    end else begin
                        pending_q <= taken_q;
                        cur       <= S_FETCH;
                    end
`else
                    cur <= halt_q ? S_HALT : S_FETCH;
`endif
                end
                S_HALT:   cur <= S_HALT;
                default:  cur <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_load    = 1'b0;
        alu_src    = 1'b0;
        reg_dst    = 2'd0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        link       = 1'b0;
        tgt_latch  = 1'b0;
        tgt_sel    = 2'd0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        active     = 1'b0;
        state      = 3'd0;
        if (!reset) begin
            active = (cur != S_HALT);
            state  = cur;
            case (cur)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_load  = !waitrequest;
                end
                S_DECODE: begin
                    if (cond_taken && !in_slot) begin
                        tgt_latch = 1'b1;
                        tgt_sel   = (is_jr || is_jalr) ? 2'd2 : ((is_j || is_jal) ? 2'd1 : 2'd0);
                    end
                end
                S_EXEC:  alu_src = is_ialu | is_load | is_store;
                S_MEM: begin
                    mem_read  = is_load;
                    mem_write = is_store && !is_load;
                end
                S_WB: begin
                    reg_write  = writes;
                    mem_to_reg = is_load;
                    link       = link31 | is_jalr;
                    reg_dst    = link31 ? 2'd2 : (is_r ? 2'd1 : 2'd0);
                    pc_write   = 1'b1;
                    pc_sel     = wb_pc_sel;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed scenarios plus random instructions vs a spec-level model.
module tb_mips_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr, rs_data, rt_data;
    logic        waitrequest;
    logic        mem_read, mem_write, ir_load, alu_src, reg_write, mem_to_reg, link;
    logic        tgt_latch, pc_write, pc_sel, active;
    logic [1:0]  reg_dst, tgt_sel;
    logic [2:0]  state;

    int n_checks = 0;
    int n_fail   = 0;

    mips_multicycle_ctrl #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
        .waitrequest(waitrequest), .mem_read(mem_read), .mem_write(mem_write), .ir_load(ir_load),
        .alu_src(alu_src), .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .link(link), .tgt_latch(tgt_latch), .tgt_sel(tgt_sel), .pc_write(pc_write),
        .pc_sel(pc_sel), .active(active), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cycles;
        logic [63:0] trace;
        logic        tl;
        logic [1:0]  ts;
        logic        rw;
        logic [1:0]  rd;
        logic        lk;
        logic        m2r;
        logic        ps;
        logic        asrc;
        int          n_fetch_rd, n_irload, n_rd_mem, n_wr_mem, n_both, n_pcw, n_stray;
        logic [2:0]  next;
        logic        act;
        logic        act0;
        logic        timeout;
    } obs_t;

    // Model state: outstanding delay-slot transfer and its deferred halt.
    bit m_pending = 0;
    bit m_hsave   = 0;

    localparam logic [31:0] ADDU  = {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    localparam logic [31:0] ADDIU = {6'd9, 5'd1, 5'd2, 16'h0004};
    localparam logic [31:0] LW    = {6'd35, 5'd1, 5'd2, 16'h0010};
    localparam logic [31:0] SW    = {6'd43, 5'd1, 5'd2, 16'h0010};
    localparam logic [31:0] BEQ   = {6'd4, 5'd1, 5'd2, 16'h0003};
    localparam logic [31:0] BGEZ  = {6'd1, 5'd1, 5'd1, 16'h0003};
    localparam logic [31:0] BLTZAL= {6'd1, 5'd1, 5'd16, 16'h0003};
    localparam logic [31:0] JR    = {6'd0, 5'd1, 15'd0, 6'd8};

    task automatic model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                         input int fw, input int mw, output obs_t e);
        int        op, rtf, fn;
        int signed rss;
        bit        taken, halt, ld, st;
        op = int'(ins[31:26]); rtf = int'(ins[20:16]); fn = int'(ins[5:0]);
        rss = int'(rs);
        taken = 0; halt = 0; ld = 0; st = 0;
        e = '{default: 0};
        case (op)
            0: begin
                if (fn == 8) begin taken = 1; e.ts = 2; halt = (rs == 0); end
                else if (fn == 9) begin taken = 1; e.ts = 2; halt = (rs == 0); e.rw = 1; e.lk = 1; e.rd = 1; end
                else begin e.rw = 1; e.rd = 1; end
            end
            1: case (rtf)
                0:  taken = rss < 0;
                1:  taken = rss >= 0;
                16: begin taken = rss < 0;  e.rw = 1; e.lk = 1; e.rd = 2; end
                17: begin taken = rss >= 0; e.rw = 1; e.lk = 1; e.rd = 2; end
                default: ;
            endcase
            2: begin taken = 1; e.ts = 1; end
            3: begin taken = 1; e.ts = 1; e.rw = 1; e.lk = 1; e.rd = 2; end
            4: taken = (rs == rt);
            5: taken = (rs != rt);
            6: if (rtf == 0) taken = rss <= 0;
            7: if (rtf == 0) taken = rss > 0;
            8, 9, 10, 11, 12, 13, 14, 15: begin e.rw = 1; e.asrc = 1; end
            32, 33, 34, 35, 36, 37, 38, 39: begin ld = 1; e.rw = 1; e.m2r = 1; e.asrc = 1; end
            43: begin st = 1; e.asrc = 1; end
            default: ;
        endcase
        for (int i = 0; i <= fw; i++) e.trace = {e.trace[60:0], 3'd0};
        e.trace = {e.trace[60:0], 3'd1};
        e.trace = {e.trace[60:0], 3'd2};
        if (ld || st) for (int i = 0; i <= mw; i++) e.trace = {e.trace[60:0], 3'd3};
        e.trace = {e.trace[60:0], 3'd4};
        e.cycles     = 4 + fw + ((ld || st) ? 1 + mw : 0);
        e.n_fetch_rd = fw + 1;
        e.n_irload   = 1;
        e.n_rd_mem   = ld ? mw + 1 : 0;
        e.n_wr_mem   = st ? mw + 1 : 0;
        e.n_pcw      = 1;
`ifdef MIPS_DELAY_SLOT_EN
        if (m_pending) begin
            e.tl = 0; e.ps = 1; e.next = m_hsave ? 3'd5 : 3'd0; m_pending = 0;
        end else begin
            e.tl = taken; e.ps = 0; e.next = 3'd0; m_pending = taken; m_hsave = taken && halt;
        end
`else
        e.tl = taken; e.ps = taken; e.next = (taken && halt) ? 3'd5 : 3'd0;
`endif
        e.act = (e.next != 3'd5);
    endtask

    // Drives one instruction from FETCH through WB; call and return at a falling edge.
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt,
                             input int fw, input int mw, output obs_t o);
        int         fc, mc;
        bit         done;
        logic [2:0] st;
        fc = 0; mc = 0; done = 0;
        o = '{default: 0};
        instr = ins; rs_data = rs; rt_data = rt;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            st = state;
            if (st == 3'd0) begin waitrequest = (fc < fw); fc++; end
            else if (st == 3'd3) begin waitrequest = (mc < mw); mc++; end
            else waitrequest = 1'($urandom_range(0, 1));
            #1;
            if (cyc == 0) o.act0 = active;
            o.cycles++;
            o.trace = {o.trace[60:0], st};
            if (mem_read && mem_write) o.n_both++;
            if (pc_write) o.n_pcw++;
            if (ir_load) o.n_irload++;
            case (st)
                3'd0: if (mem_read) o.n_fetch_rd++;
                3'd1: begin o.tl = tgt_latch; o.ts = tgt_sel; if (mem_read || mem_write) o.n_stray++; end
                3'd2: begin o.asrc = alu_src; if (mem_read || mem_write) o.n_stray++; end
                3'd3: begin if (mem_read) o.n_rd_mem++; if (mem_write) o.n_wr_mem++; end
                3'd4: begin
                    o.rw = reg_write; o.rd = reg_dst; o.lk = link; o.m2r = mem_to_reg; o.ps = pc_sel;
                    if (mem_read || mem_write) o.n_stray++;
                    done = 1;
                end
                default: ;
            endcase
            @(negedge clk);
        end
        o.timeout = !done;
        o.next = state;
        o.act  = active;
    endtask

    task automatic test_reset;
        obs_t o, e;
        reset = 1'b1; waitrequest = 1'b0; instr = 32'd0; rs_data = 32'd0; rt_data = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({mem_read, mem_write, ir_load, alu_src, reg_dst, reg_write, mem_to_reg, link,
                 tgt_latch, tgt_sel, pc_write, pc_sel, active, state} !== 18'd0) begin
                n_fail++; $display("FAIL reset_outputs_zero cycle %0d: active=%0b state=%0d mem_read=%0b", i, active, state, mem_read);
            end
        end
        reset = 1'b0; m_pending = 0; m_hsave = 0;
        model(ADDU, 32'd0, 32'd0, 0, 0, e);
        run_instr(ADDU, 32'd0, 32'd0, 0, 0, o);
        n_checks++; if (o.trace !== 64'o124) begin n_fail++; $display("FAIL addu_trace: got %0o want 124", o.trace); end
        n_checks++; if (o.cycles !== 4) begin n_fail++; $display("FAIL addu_cycles: got %0d want 4", o.cycles); end
        n_checks++; if (o.act0 !== 1'b1) begin n_fail++; $display("FAIL addu_active_after_release: got %0b want 1", o.act0); end
        n_checks++; if (o.rw !== 1'b1 || o.rd !== 2'd1) begin n_fail++; $display("FAIL addu_wb: got rw=%0b rd=%0d want rw=1 rd=1", o.rw, o.rd); end
        n_checks++; if (o.next !== e.next) begin n_fail++; $display("FAIL addu_next: got %0d want %0d", o.next, e.next); end
    endtask

    task automatic test_lw_wait;
        obs_t o, e;
        model(LW, 32'h100, 32'd0, 2, 2, e);
        run_instr(LW, 32'h100, 32'd0, 2, 2, o);
        n_checks++; if (o.cycles !== 9) begin n_fail++; $display("FAIL lw_cycles: got %0d want 9", o.cycles); end
        n_checks++; if (o.trace !== e.trace) begin n_fail++; $display("FAIL lw_trace: got %0o want %0o", o.trace, e.trace); end
        n_checks++; if (o.n_fetch_rd !== 3 || o.n_rd_mem !== 3) begin n_fail++; $display("FAIL lw_read_held: got fetch=%0d mem=%0d want 3 3", o.n_fetch_rd, o.n_rd_mem); end
        n_checks++; if (o.m2r !== 1'b1 || o.rd !== 2'd0 || o.rw !== 1'b1) begin n_fail++; $display("FAIL lw_wb: got m2r=%0b rd=%0d rw=%0b want 1 0 1", o.m2r, o.rd, o.rw); end
        n_checks++; if (o.n_wr_mem !== 0 || o.n_both !== 0) begin n_fail++; $display("FAIL lw_no_write: got wr=%0d both=%0d want 0 0", o.n_wr_mem, o.n_both); end
    endtask

    task automatic test_bgez;
        obs_t o, e;
        model(BGEZ, 32'hFFFF_FFFF, 32'd0, 0, 0, e);
        run_instr(BGEZ, 32'hFFFF_FFFF, 32'd0, 0, 0, o);
        n_checks++; if (o.tl !== 1'b0 || o.ps !== 1'b0) begin n_fail++; $display("FAIL bgez_neg_not_taken: got tl=%0b ps=%0b want 0 0", o.tl, o.ps); end
        model(BGEZ, 32'd0, 32'd0, 0, 0, e);
        run_instr(BGEZ, 32'd0, 32'd0, 0, 0, o);
        n_checks++; if (o.tl !== 1'b1 || o.ts !== 2'd0) begin n_fail++; $display("FAIL bgez_zero_taken: got tl=%0b ts=%0d want 1 0", o.tl, o.ts); end
        n_checks++; if (o.ps !== e.ps) begin n_fail++; $display("FAIL bgez_pc_sel: got %0b want %0b", o.ps, e.ps); end
        model(ADDU, 32'd1, 32'd2, 0, 0, e);
        run_instr(ADDU, 32'd1, 32'd2, 0, 0, o);
        n_checks++; if (o.ps !== e.ps) begin n_fail++; $display("FAIL bgez_follow_pc_sel: got %0b want %0b", o.ps, e.ps); end
    endtask

    task automatic test_bltzal;
        obs_t o, e;
        model(BLTZAL, 32'd5, 32'd0, 0, 0, e);
        run_instr(BLTZAL, 32'd5, 32'd0, 0, 0, o);
        n_checks++; if (o.rw !== 1'b1 || o.rd !== 2'd2 || o.lk !== 1'b1) begin n_fail++; $display("FAIL bltzal_link: got rw=%0b rd=%0d lk=%0b want 1 2 1", o.rw, o.rd, o.lk); end
        n_checks++; if (o.ps !== 1'b0 || o.tl !== 1'b0) begin n_fail++; $display("FAIL bltzal_not_taken: got ps=%0b tl=%0b want 0 0", o.ps, o.tl); end
    endtask

    task automatic test_random;
        obs_t        o, e;
        logic [31:0] ins, rs, rt;
        logic [4:0]  rtf;
        int          fw, mw;
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 3))
                0: rtf = 5'd0; 1: rtf = 5'd1; 2: rtf = 5'd16; default: rtf = 5'd17;
            endcase
            case ($urandom_range(0, 15))
                0:  ins = ADDU;
                1:  ins = ADDIU;
                2:  ins = {6'd13, 5'd1, 5'd2, 16'h00FF};
                3:  ins = LW;
                4:  ins = {6'd32, 5'd1, 5'd2, 16'h0001};
                5:  ins = SW;
                6:  ins = BEQ;
                7:  ins = {6'd5, 5'd1, 5'd2, 16'h0002};
                8:  ins = {6'd6, 5'd1, ($urandom_range(0, 1) != 0) ? 5'd0 : 5'd3, 16'h0002};
                9:  ins = {6'd7, 5'd1, 5'd0, 16'h0002};
                10: ins = {6'd1, 5'd1, ($urandom_range(0, 4) == 0) ? 5'd5 : rtf, 16'h0002};
                11: ins = {6'd2, 26'h0123};
                12: ins = {6'd3, 26'h0456};
                13: ins = JR;
                14: ins = {6'd0, 5'd1, 5'd0, 5'd31, 5'd0, 6'd9};
                default: ins = {6'd20, 5'd1, 5'd2, 16'h0007};
            endcase
            case ($urandom_range(0, 5))
                0: rs = 32'd0; 1: rs = 32'd5; 2: rs = 32'hFFFF_FFFF;
                3: rs = 32'h8000_0000; 4: rs = 32'h7FFF_FFFF; default: rs = $urandom;
            endcase
            rt = ($urandom_range(0, 1) != 0) ? rs : $urandom;
            if (ins[31:26] == 6'd0 && (ins[5:0] == 6'd8 || ins[5:0] == 6'd9) && rs == 32'd0) rs = 32'd4;
            fw = $urandom_range(0, 2); mw = $urandom_range(0, 2);
            model(ins, rs, rt, fw, mw, e);
            run_instr(ins, rs, rt, fw, mw, o);
            n_checks++; if (o.timeout !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_timeout: instr %h did not reach WB", n, ins); end
            n_checks++; if (o.trace !== e.trace || o.cycles !== e.cycles) begin n_fail++; $display("FAIL rnd%0d_seq instr %h: got %0o/%0d want %0o/%0d", n, ins, o.trace, o.cycles, e.trace, e.cycles); end
            n_checks++; if (o.tl !== e.tl || (e.tl && o.ts !== e.ts)) begin n_fail++; $display("FAIL rnd%0d_target instr %h rs %h rt %h: got tl=%0b ts=%0d want %0b %0d", n, ins, rs, rt, o.tl, o.ts, e.tl, e.ts); end
            n_checks++; if (o.rw !== e.rw || (e.rw && o.rd !== e.rd)) begin n_fail++; $display("FAIL rnd%0d_write instr %h: got rw=%0b rd=%0d want %0b %0d", n, ins, o.rw, o.rd, e.rw, e.rd); end
            n_checks++; if (o.lk !== e.lk || o.m2r !== e.m2r || o.asrc !== e.asrc) begin n_fail++; $display("FAIL rnd%0d_mux instr %h: got lk=%0b m2r=%0b asrc=%0b want %0b %0b %0b", n, ins, o.lk, o.m2r, o.asrc, e.lk, e.m2r, e.asrc); end
            n_checks++; if (o.ps !== e.ps) begin n_fail++; $display("FAIL rnd%0d_pc_sel instr %h rs %h rt %h: got %0b want %0b", n, ins, rs, rt, o.ps, e.ps); end
            n_checks++; if (o.n_fetch_rd !== e.n_fetch_rd || o.n_irload !== 1 || o.n_rd_mem !== e.n_rd_mem || o.n_wr_mem !== e.n_wr_mem) begin
                n_fail++; $display("FAIL rnd%0d_strobes instr %h: got f=%0d ir=%0d r=%0d w=%0d want %0d 1 %0d %0d", n, ins, o.n_fetch_rd, o.n_irload, o.n_rd_mem, o.n_wr_mem, e.n_fetch_rd, e.n_rd_mem, e.n_wr_mem);
            end
            n_checks++; if (o.n_both !== 0 || o.n_stray !== 0 || o.n_pcw !== 1) begin n_fail++; $display("FAIL rnd%0d_exclusive instr %h: got both=%0d stray=%0d pcw=%0d want 0 0 1", n, ins, o.n_both, o.n_stray, o.n_pcw); end
            n_checks++; if (o.next !== e.next || o.act !== e.act) begin n_fail++; $display("FAIL rnd%0d_next instr %h: got %0d/%0b want %0d/%0b", n, ins, o.next, o.act, e.next, e.act); end
        end
    endtask

    task automatic test_reset_mid_mem;
        bit reached;
        reached = 0;
        instr = SW; rs_data = 32'h40; rt_data = 32'h55;
        for (int i = 0; i < 20 && !reached; i++) begin
            waitrequest = (state == 3'd0) ? 1'b0 : 1'b1;
            #1;
            if (state == 3'd3) reached = 1;
            else @(negedge clk);
        end
        n_checks++; if (!reached || mem_write !== 1'b1) begin n_fail++; $display("FAIL sw_mem_stall: got reached=%0b mem_write=%0b want 1 1", reached, mem_write); end
        reset = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (mem_write !== 1'b0 || state !== 3'd0) begin n_fail++; $display("FAIL reset_mid_mem: got mem_write=%0b state=%0d want 0 0", mem_write, state); end
        @(negedge clk);
        reset = 1'b0; waitrequest = 1'b1; m_pending = 0; m_hsave = 0;
        #1;
        n_checks++; if (state !== 3'd0 || mem_write !== 1'b0 || mem_read !== 1'b1 || active !== 1'b1) begin
            n_fail++; $display("FAIL reset_mid_mem_fetch: got state=%0d wr=%0b rd=%0b act=%0b want 0 0 1 1", state, mem_write, mem_read, active);
        end
    endtask

    task automatic test_jr_halt;
        obs_t o, e;
        model(JR, 32'd0, 32'd0, 0, 0, e);
        run_instr(JR, 32'd0, 32'd0, 0, 0, o);
        n_checks++; if (o.tl !== 1'b1 || o.ts !== 2'd2 || o.rw !== 1'b0) begin n_fail++; $display("FAIL jr_target: got tl=%0b ts=%0d rw=%0b want 1 2 0", o.tl, o.ts, o.rw); end
        n_checks++; if (o.next !== e.next) begin n_fail++; $display("FAIL jr_next: got %0d want %0d", o.next, e.next); end
        if (e.next != 3'd5) begin
            model(ADDIU, 32'd3, 32'd0, 0, 0, e);
            run_instr(ADDIU, 32'd3, 32'd0, 0, 0, o);
            n_checks++; if (o.rw !== 1'b1 || o.ps !== 1'b1) begin n_fail++; $display("FAIL slot_wb: got rw=%0b ps=%0b want 1 1", o.rw, o.ps); end
            n_checks++; if (o.next !== 3'd5) begin n_fail++; $display("FAIL slot_halt: got %0d want 5", o.next); end
        end
        instr = BEQ; rs_data = 32'd7; rt_data = 32'd7;
        for (int i = 0; i < 5; i++) begin
            waitrequest = 1'($urandom_range(0, 1));
            #1;
            n_checks++; if (state !== 3'd5 || active !== 1'b0) begin n_fail++; $display("FAIL halt_hold cycle %0d: got state=%0d active=%0b want 5 0", i, state, active); end
            n_checks++; if ({mem_read, mem_write, ir_load, reg_write, pc_write, tgt_latch} !== 6'd0) begin n_fail++; $display("FAIL halt_quiet cycle %0d: got strobes %b want 000000", i, {mem_read, mem_write, ir_load, reg_write, pc_write, tgt_latch}); end
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; m_pending = 0; m_hsave = 0;
        #1;
        n_checks++; if (state !== 3'd0 || active !== 1'b1) begin n_fail++; $display("FAIL halt_exit_reset: got state=%0d active=%0b want 0 1", state, active); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lw_wait();
        test_bgez();
        test_bltzal();
        test_random();
        test_reset_mid_mem();
        test_jr_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control unit for the MIPS CPU core. It is the sequential successor to the combinational control-signal decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and stalls on Avalon `waitrequest`. It resolves every branch and jump, including the link variants, against register operands with a configurable data width. It drives the datapath muxes, register-file write, PC update and the halt condition.

## Interface
- `DATA_WIDTH`, 32, width of register operands `rs_data`/`rt_data`
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high
- `instr`  in  32  instruction register contents, valid from DECODE onward
- `rs_data`  in  DATA_WIDTH  register-file read port 1, two's complement
- `rt_data`  in  DATA_WIDTH  register-file read port 2
- `waitrequest`  in  1  Avalon stall from memory
- `mem_read`  out  1  Avalon read strobe (FETCH, load MEM)
- `mem_write`  out  1  Avalon write strobe (store MEM)
- `ir_load`  out  1  latch `readdata` into instruction register
- `alu_src`  out  1  1 = sign-extended immediate, 0 = `rt_data`
- `reg_dst`  out  2  0 = rt, 1 = rd, 2 = r31
- `reg_write`  out  1  register-file write enable (WB only)
- `mem_to_reg`  out  1  write-back from memory data
- `link`  out  1  write-back value is PC+8
- `tgt_latch`  out  1  datapath captures control-transfer target
- `tgt_sel`  out  2  0 = PC+4+(simm<<2), 1 = {PC[31:28],imm26,2'b00}, 2 = `rs_data`
- `pc_write`  out  1  update PC
- `pc_sel`  out  1  0 = PC+4, 1 = target register
- `active`  out  1  CPU running
- `state`  out  3  current state, for debug

## Operation
- States are FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- FETCH: `mem_read`=1 until `waitrequest`=0. In that cycle, `ir_load`=1 and the next state is DECODE.
- DECODE: classify the instruction and evaluate the branch condition. A taken transfer pulses `tgt_latch` with the appropriate `tgt_sel`. The taken flag and halt flag are registered. Next state is EXEC.
- Branch conditions, signed over DATA_WIDTH:
  - BEQ (op 4): `rs==rt`
  - BNE (op 5): `rs!=rt`
  - BLEZ (op 6, rt=0): `rs<=0`
  - BGTZ (op 7, rt=0): `rs>0`
  - REGIMM (op 1), selected by rt: 0 BLTZ `rs<0`; 1 BGEZ `rs>=0`; 16 BLTZAL; 17 BGEZAL.
  - J (op 2), JAL (op 3), JR (funct 8) and JALR (funct 9) are always taken.
- Link writes: JAL, BLTZAL and BGEZAL write r31 with `link`=1. The link write happens whether or not the branch is taken. JALR writes rd with `link`=1.
- JR or JALR with `rs_data`==0 sets the halt flag.
- EXEC: loads (op[5:3]=100) and stores (op 43) go to MEM. Everything else goes to WB. `alu_src`=1 for I-type ALU, loads and stores.
- MEM: `mem_read` (loads) or `mem_write` (stores) is held until `waitrequest`=0, then the next state is WB.
- WB:
  - `reg_write` is 1 for R-type, I-type ALU (op[5:3]=001), loads and links. Stores, branches without link, J and JR do not write.
  - `mem_to_reg`=1 for loads.
  - `pc_write`=1 always.
  - Next state is HALT if the halt flag is effective, else FETCH.
- Unknown opcode executes as a NOP: EXEC→WB with no write, PC+4.
- Strobes are otherwise 0. `mem_read` and `mem_write` are never both 1.

## Timing
- Reset: the state becomes FETCH on the cycle after reset is sampled high. While reset is asserted, all outputs are 0, including `active`, and the pending and halt flags are cleared. Reset mid-MEM abandons the access and drops strobes on the next edge.
- `active`=1 in all states except HALT and the reset cycles. HALT is exited only by reset.
- Minimum latency with zero wait: ALU/branch/jump 4 cycles (F,D,E,W), load/store 5 cycles. Each `waitrequest` cycle adds one.
- `waitrequest` is ignored outside FETCH and MEM.
- Control outputs are combinational from state and registered flags. `tgt_latch` is combinational from `instr`/`rs_data`/`rt_data` in DECODE only.
- Simultaneous taken transfer in a delay slot: the slot's own transfer is ignored, with no `tgt_latch` and no pending overwrite. Its link write still occurs.

## Configuration
- `MIPS_DELAY_SLOT_EN` defined:
  - In a taken transfer's WB, `pc_sel`=0 and the pending flag is set.
  - The next instruction (the delay slot) executes normally. In its WB, `pc_sel`=1 and pending is cleared.
  - Halt takes effect at the slot's WB.
- Undefined: a taken transfer's own WB uses `pc_sel`=1, no pending flag exists, and halt takes effect at that WB.

## Test plan
- Reset held 3 cycles, then release with `waitrequest`=0 and ADDU fetched:
  - Required: state 0→1→2→4; `reg_write`=1, `reg_dst`=1 in WB; `active`=1 from the cycle after release.
- LW with `waitrequest` high 2 cycles in both FETCH and MEM:
  - Required: total 9 cycles; `mem_read` held throughout each stall; `mem_to_reg`=1, `reg_dst`=0 in WB.
- BGEZ with `rs_data`=32'hFFFF_FFFF, then with `rs_data`=0:
  - First case required: not taken, `tgt_latch`=0, `pc_sel`=0.
  - Second case required: `tgt_latch`=1, `tgt_sel`=0, target applied per delay-slot mode.
- BLTZAL with `rs_data`=5 (not taken):
  - Required: `reg_write`=1, `reg_dst`=2, `link`=1; PC+4.
- JR with `rs_data`=0 under `MIPS_DELAY_SLOT_EN`, slot = ADDIU:
  - Required: the slot writes back; state becomes 5; `active`=0; later BEQ stimuli are ignored until reset.
- Reset asserted during a store MEM stall:
  - Required: `mem_write`=0 and state=0 on the following edge.
